// File: rtl/cnn_frame_ctrl_pkg.sv
// Shared constants for the CNN frame sequencer: state encodings, error codes,
// and per-stage beat counts derived from the 28x28 / 5x5 / 2x2 network shape.
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    localparam int IMG_W  = 28;
    localparam int KER_W  = 5;
    localparam int POOL_K = 2;

    // Valid convolutions shrink by KER_W-1; pooling divides by POOL_K.
    localparam int CONV1_W = IMG_W - KER_W + 1;
    localparam int POOL_W  = CONV1_W / POOL_K;
    localparam int ST2_W   = POOL_W - KER_W + 1;

    localparam int CONV1_BEATS_DEF = CONV1_W * CONV1_W;
    localparam int POOL_BEATS_DEF  = POOL_W * POOL_W;
    localparam int ST2_BEATS_DEF   = ST2_W * ST2_W;

endpackage

// File: rtl/cnn_frame_ctrl_if.sv
// Control/status bundle between the frame sequencer and the pipeline / host side.
interface cnn_frame_ctrl_if #(
    parameter int ALPHA_BW = 8
);
    logic                i_start;
    logic                i_clear;
    logic                i_conv1_valid;
    logic                i_pool_valid;
    logic                i_st2_valid;
    logic                i_cls_valid;
    logic [ALPHA_BW-1:0] i_cls_alpha;
    logic                o_feed_start;
    logic                o_busy;
    logic                o_done;
    logic [ALPHA_BW-1:0] o_result_alpha;
    logic                o_err;
    logic [1:0]          o_err_code;
    logic [2:0]          o_state;

    modport master (
        output i_start, i_clear, i_conv1_valid, i_pool_valid, i_st2_valid,
               i_cls_valid, i_cls_alpha,
        input  o_feed_start, o_busy, o_done, o_result_alpha, o_err, o_err_code, o_state
    );

    modport slave (
        input  i_start, i_clear, i_conv1_valid, i_pool_valid, i_st2_valid,
               i_cls_valid, i_cls_alpha,
        output o_feed_start, o_busy, o_done, o_result_alpha, o_err, o_err_code, o_state
    );
endinterface

// File: rtl/cnn_frame_ctrl_beat_counter.sv
// Saturating per-stage valid-beat counter; flags a beat arriving once the
// expected count has already been reached.
module ctrl_beat_counter #(
    parameter int N = 576,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         enable,
    input  logic         valid,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         overflow
);

    logic [W-1:0] count_q, count_d;

    assign at_max   = (count_q == W'(N));
    assign overflow = valid && at_max;
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable && valid && !at_max)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer: launches one frame at a time, audits per-stage beat counts,
// latches the classifier result and reports done / busy / sticky error.
module cnn_frame_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int CONV1_BEATS = CONV1_BEATS_DEF,
    parameter int POOL_BEATS  = POOL_BEATS_DEF,
    parameter int ST2_BEATS   = ST2_BEATS_DEF,
    parameter int TIMEOUT_CYC = 20000,
    parameter int ALPHA_BW    = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    cnn_frame_ctrl_if.slave bus
);

    localparam int C1W = $clog2(CONV1_BEATS + 1);
    localparam int PLW = $clog2(POOL_BEATS + 1);
    localparam int S2W = $clog2(ST2_BEATS + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC);

    state_e              state_q, state_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ALPHA_BW-1:0] alpha_q, alpha_d;
    logic                feed_start_q, busy_q, done_q, err_q;
    logic                cnt_clear, run;

    logic [C1W-1:0] c1_cnt;
    logic [PLW-1:0] pl_cnt;
    logic [S2W-1:0] s2_cnt;
    logic c1_max, pl_max, s2_max, c1_ovf, pl_ovf, s2_ovf;
    logic any_ovf, counts_ok;

    assign run = (state_q == ST_RUN);

    ctrl_beat_counter #(.N(CONV1_BEATS), .W(C1W)) u_cnt_conv1 (
        .clk(clk), .reset_n(reset_n), .clear(cnt_clear), .enable(run),
        .valid(bus.i_conv1_valid), .count(c1_cnt), .at_max(c1_max), .overflow(c1_ovf));
    ctrl_beat_counter #(.N(POOL_BEATS), .W(PLW)) u_cnt_pool (
        .clk(clk), .reset_n(reset_n), .clear(cnt_clear), .enable(run),
        .valid(bus.i_pool_valid), .count(pl_cnt), .at_max(pl_max), .overflow(pl_ovf));
    ctrl_beat_counter #(.N(ST2_BEATS), .W(S2W)) u_cnt_st2 (
        .clk(clk), .reset_n(reset_n), .clear(cnt_clear), .enable(run),
        .valid(bus.i_st2_valid), .count(s2_cnt), .at_max(s2_max), .overflow(s2_ovf));

    // The classifier check must see beats landing on the same edge as i_cls_valid.
    assign counts_ok = (c1_max || (bus.i_conv1_valid && c1_cnt == C1W'(CONV1_BEATS - 1))) &&
                       (pl_max || (bus.i_pool_valid  && pl_cnt == PLW'(POOL_BEATS - 1)))  &&
                       (s2_max || (bus.i_st2_valid   && s2_cnt == S2W'(ST2_BEATS - 1)));
    assign any_ovf   = c1_ovf || pl_ovf || s2_ovf;

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        err_code_d = err_code_q;
        alpha_d    = alpha_q;
        cnt_clear  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (bus.i_start) begin
                state_d   = ST_LAUNCH;
                tmo_d     = '0;
                cnt_clear = 1'b1;
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
                tmo_d   = tmo_q + TW'(1);
            end
            ST_RUN: begin
                if (any_ovf) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_OVERFLOW;
                end else if (bus.i_cls_valid) begin
                    if (counts_ok) begin
                        state_d = ST_DONE;
                        alpha_d = bus.i_cls_alpha;
                    end else begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_MISMATCH;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR: if (bus.i_clear) begin
                state_d    = ST_IDLE;
                err_code_d = ERR_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they line up with o_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            err_code_q   <= ERR_NONE;
            alpha_q      <= '0;
            feed_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            err_code_q   <= err_code_d;
            alpha_q      <= alpha_d;
            feed_start_q <= (state_d == ST_LAUNCH);
            busy_q       <= (state_d == ST_LAUNCH) || (state_d == ST_RUN);
            done_q       <= (state_d == ST_DONE);
            err_q        <= (state_d == ST_ERR);
        end
    end

    assign bus.o_feed_start   = feed_start_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_result_alpha = alpha_q;
    assign bus.o_err          = err_q;
    assign bus.o_err_code     = err_code_q;
    assign bus.o_state        = state_q;

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Directed bench for cnn_frame_ctrl: nominal, mismatch, overflow, timeout,
// busy rejection and mid-frame reset.
module tb_cnn_frame_ctrl;
    import cnn_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cnn_frame_ctrl_if #(.ALPHA_BW(8)) bus_a ();
    cnn_frame_ctrl_if #(.ALPHA_BW(8)) bus_b ();

    cnn_frame_ctrl #(.TIMEOUT_CYC(20000)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_a));
    cnn_frame_ctrl #(.TIMEOUT_CYC(100)) u_dut_t (
        .clk(clk), .reset_n(reset_n), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        bus_a.i_start = 0; bus_a.i_clear = 0; bus_a.i_cls_valid = 0; bus_a.i_cls_alpha = '0;
        bus_a.i_conv1_valid = 0; bus_a.i_pool_valid = 0; bus_a.i_st2_valid = 0;
        bus_b.i_start = 0; bus_b.i_clear = 0; bus_b.i_cls_valid = 0; bus_b.i_cls_alpha = '0;
        bus_b.i_conv1_valid = 0; bus_b.i_pool_valid = 0; bus_b.i_st2_valid = 0;
    endtask

    task automatic launch_a(input string tag);
        bus_a.i_start = 1;
        chk({tag, "_pre_feed"}, bus_a.o_feed_start, 0);
        step();
        chk({tag, "_launch_state"}, bus_a.o_state, ST_LAUNCH);
        chk({tag, "_feed_start"}, bus_a.o_feed_start, 1);
        chk({tag, "_busy_launch"}, bus_a.o_busy, 1);
        bus_a.i_start = 0;
        step();
        chk({tag, "_run_state"}, bus_a.o_state, ST_RUN);
        chk({tag, "_feed_one_cycle"}, bus_a.o_feed_start, 0);
    endtask

    // Drives the three stage valids concurrently; optionally pokes i_start.
    task automatic send_beats(input int n1, input int n2, input int n3,
                              input bit poke_start, output bit feed_seen);
        int m;
        m = n1;
        if (n2 > m) m = n2;
        if (n3 > m) m = n3;
        feed_seen = 0;
        for (int i = 0; i < m; i++) begin
            bus_a.i_conv1_valid = (i < n1);
            bus_a.i_pool_valid  = (i < n2);
            bus_a.i_st2_valid   = (i < n3);
            bus_a.i_start       = poke_start && (i % 37 == 0);
            step();
            feed_seen |= bus_a.o_feed_start;
        end
        bus_a.i_conv1_valid = 0; bus_a.i_pool_valid = 0; bus_a.i_st2_valid = 0;
        bus_a.i_start = 0;
    endtask

    task automatic classify(input logic [7:0] alpha);
        bus_a.i_cls_valid = 1;
        bus_a.i_cls_alpha = alpha;
        step();
        bus_a.i_cls_valid = 0;
        bus_a.i_cls_alpha = '0;
    endtask

    initial begin
        bit seen;
        zero_inputs();
        step(); step();
        chk("rst_state", bus_a.o_state, ST_IDLE);
        chk("rst_busy", bus_a.o_busy, 0);
        chk("rst_feed", bus_a.o_feed_start, 0);
        chk("rst_done", bus_a.o_done, 0);
        chk("rst_err", bus_a.o_err, 0);
        chk("rst_code", bus_a.o_err_code, 0);
        chk("rst_alpha", bus_a.o_result_alpha, 0);
        reset_n = 1;
        step();

        // 1. nominal frame
        launch_a("t1");
        send_beats(576, 144, 64, 0, seen);
        chk("t1_still_run", bus_a.o_state, ST_RUN);
        classify(8'h41);
        chk("t1_done_state", bus_a.o_state, ST_DONE);
        chk("t1_done", bus_a.o_done, 1);
        chk("t1_alpha", bus_a.o_result_alpha, 8'h41);
        step();
        chk("t1_idle", bus_a.o_state, ST_IDLE);
        chk("t1_done_pulse", bus_a.o_done, 0);
        chk("t1_busy_low", bus_a.o_busy, 0);
        chk("t1_err", bus_a.o_err, 0);

        // 2. pool count short by one
        launch_a("t2");
        send_beats(576, 143, 64, 0, seen);
        classify(8'h55);
        chk("t2_state", bus_a.o_state, ST_ERR);
        chk("t2_err", bus_a.o_err, 1);
        chk("t2_code", bus_a.o_err_code, ERR_MISMATCH);
        chk("t2_alpha_kept", bus_a.o_result_alpha, 8'h41);
        step();
        chk("t2_sticky", bus_a.o_err, 1);
        bus_a.i_clear = 1;
        step();
        bus_a.i_clear = 0;
        chk("t2_clr_state", bus_a.o_state, ST_IDLE);
        chk("t2_clr_err", bus_a.o_err, 0);
        chk("t2_clr_code", bus_a.o_err_code, ERR_NONE);

        // 3. 65th st2 beat
        launch_a("t3");
        send_beats(0, 0, 64, 0, seen);
        chk("t3_run_at_max", bus_a.o_state, ST_RUN);
        bus_a.i_st2_valid = 1;
        step();
        bus_a.i_st2_valid = 0;
        chk("t3_state", bus_a.o_state, ST_ERR);
        chk("t3_code", bus_a.o_err_code, ERR_OVERFLOW);
        classify(8'h66);
        chk("t3_code_hold", bus_a.o_err_code, ERR_OVERFLOW);
        chk("t3_alpha_hold", bus_a.o_result_alpha, 8'h41);
        bus_a.i_clear = 1;
        step();
        bus_a.i_clear = 0;
        chk("t3_clr_state", bus_a.o_state, ST_IDLE);

        // 4. timeout on the short-timeout instance
        bus_b.i_start = 1;
        step();
        bus_b.i_start = 0;
        chk("t4_launch", bus_b.o_state, ST_LAUNCH);
        for (int i = 0; i < 99; i++) step();
        chk("t4_run_99", bus_b.o_state, ST_RUN);
        step();
        chk("t4_state_100", bus_b.o_state, ST_ERR);
        chk("t4_code", bus_b.o_err_code, ERR_TIMEOUT);
        bus_b.i_start = 1;
        bus_b.i_clear = 1;
        step();
        bus_b.i_start = 0;
        bus_b.i_clear = 0;
        chk("t4_clr_state", bus_b.o_state, ST_IDLE);
        chk("t4_clr_err", bus_b.o_err, 0);
        chk("t4_no_feed", bus_b.o_feed_start, 0);
        step();
        chk("t4_stay_idle", bus_b.o_state, ST_IDLE);
        chk("t4_no_feed2", bus_b.o_feed_start, 0);

        // 5. start pokes during RUN and held through DONE
        launch_a("t5");
        send_beats(576, 144, 64, 1, seen);
        chk("t5_no_extra_feed", seen, 0);
        chk("t5_busy", bus_a.o_busy, 1);
        bus_a.i_start = 1;
        classify(8'h42);
        chk("t5_done", bus_a.o_done, 1);
        chk("t5_feed_in_done", bus_a.o_feed_start, 0);
        step();
        chk("t5_idle_no_feed", bus_a.o_feed_start, 0);
        step();
        bus_a.i_start = 0;
        chk("t5_relaunch", bus_a.o_feed_start, 1);
        chk("t5_relaunch_state", bus_a.o_state, ST_LAUNCH);
        step();

        // 6. async reset mid-RUN of the relaunched frame
        send_beats(300, 0, 0, 0, seen);
        chk("t6_mid_run", bus_a.o_state, ST_RUN);
        #2 reset_n = 0;
        #1;
        chk("t6_rst_state", bus_a.o_state, ST_IDLE);
        chk("t6_rst_busy", bus_a.o_busy, 0);
        chk("t6_rst_alpha", bus_a.o_result_alpha, 0);
        chk("t6_rst_err", bus_a.o_err, 0);
        step();
        reset_n = 1;
        send_beats(5, 5, 5, 0, seen);
        chk("t6_idle_c1", u_dut.u_cnt_conv1.count, 0);
        chk("t6_idle_pool", u_dut.u_cnt_pool.count, 0);
        chk("t6_idle_st2", u_dut.u_cnt_st2.count, 0);
        chk("t6_idle_state", bus_a.o_state, ST_IDLE);
        launch_a("t6");
        send_beats(576, 144, 64, 0, seen);
        classify(8'h5a);
        chk("t6_done", bus_a.o_done, 1);
        chk("t6_alpha", bus_a.o_result_alpha, 8'h5a);
        step();
        chk("t6_idle_end", bus_a.o_state, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
